cfg_port_arbiter: RTL

CFG_PORT_ARBITER -- requirements
Module: cfg_port_arbiter

---
 rtl/cfg_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/cfg_port_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cfg_pkg.sv
// -----------------------------------------------------------------------------
// cfg_pkg
// Shared definitions for the config-port arbiter:
//   DATA_W  : config memory data width
//   state_t : arbiter FSM encoding (2 bits)
//   idx_w() : width of an index able to address n requesters (min 1 bit)
// -----------------------------------------------------------------------------
package cfg_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_CFG   = 2'd3
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Scans the request vector starting at
// i_ptr and wrapping from N-1 to 0; the first asserted request wins.
// Ports:
//   i_req   [N-1:0]  : request vector
//   i_ptr   [IW-1:0] : index with highest priority this cycle (< N)
//   o_grant [N-1:0]  : one-hot winner, all zero when no request
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant
);

    // One extra bit so ptr + offset never overflows before the wrap test.
    localparam int SW = IW + 1;

    logic [SW-1:0] w_sum;
    logic [IW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + SW'(k);
            if (w_sum >= SW'(N)) begin
                w_sum = w_sum - SW'(N);
            end
            w_idx = w_sum[IW-1:0];
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cfg_port_arbiter.sv
// -----------------------------------------------------------------------------
// cfg_port_arbiter
// Shares one registered config memory port between N system requesters and
// an APB configuration window.
//
// Handshake: a requester holds req[i] (with req_we/req_addr/req_wdata stable)
// until gnt[i] pulses for one cycle; that pulse means the op was issued.
// Reads additionally return rdata qualified by a one-cycle rvalid[i] pulse.
// A req dropped before its gnt is simply never seen.
//
// Ports:
//   system_clk, prstn          : clock (rising edge), async active-low reset
//   req/req_we [N]             : per-requester request and op (1 = write)
//   req_addr [N*D]             : packed addresses, requester i at [i*D +: D]
//   req_wdata [N*32]           : packed write data, requester i at [i*32 +: 32]
//   gnt/rvalid [N]             : one-hot accept / read-valid pulses
//   rdata [32]                 : shared read data, held between rvalid pulses
//   cfg_mode                   : APB config window request (wins over req)
//   cfg_state_write_enable     : registered enable for APB writes to memory
//   mem_rd_en/mem_wr_en        : memory strobes (ISSUE cycle only)
//   mem_addr [D], mem_wdata[32]: memory address / write data
//   mem_rd_data [32]           : memory read data, one cycle after mem_rd_en
//
// Timing: req sampled in IDLE (cycle 0) -> gnt + strobe (cycle 1) ->
// RESP captures mem_rd_data (cycle 2) -> rvalid (cycle 3, FSM back in IDLE).
// -----------------------------------------------------------------------------
module cfg_port_arbiter
    import cfg_pkg::*;
#(
    parameter int N = 4,
    parameter int D = 6
) (
    input  logic                system_clk,
    input  logic                prstn,
    input  logic [N-1:0]        req,
    input  logic [N-1:0]        req_we,
    input  logic [N*D-1:0]      req_addr,
    input  logic [N*DATA_W-1:0] req_wdata,
    output logic [N-1:0]        gnt,
    output logic [N-1:0]        rvalid,
    output logic [DATA_W-1:0]   rdata,
    input  logic                cfg_mode,
    output logic                cfg_state_write_enable,
    output logic                mem_rd_en,
    output logic                mem_wr_en,
    output logic [D-1:0]        mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rd_data
);

    localparam int IW = idx_w(N);

    state_t              r_state;
    state_t              w_next;

    logic [IW-1:0]       r_rr_ptr;
    logic [IW-1:0]       r_idx;
    logic                r_we;
    logic [D-1:0]        r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [N-1:0]        r_rvalid;
    logic                r_cfg_we;

    logic [N-1:0]        w_win_onehot;
    logic [IW-1:0]       w_win_idx;
    logic                w_sel_we;
    logic [D-1:0]        w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [N-1:0]        w_lat_onehot;
    logic                w_take;

    rr_arbiter #(
        .N  (N),
        .IW (IW)
    ) u_rr_arbiter (
        .i_req   (req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_win_onehot)
    );

    // One-hot winner to index plus the winner's op/addr/data, as an AND-OR mux.
    always_comb begin
        w_win_idx   = '0;
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int k = 0; k < N; k++) begin
            if (w_win_onehot[k]) begin
                w_win_idx   = IW'(k);
                w_sel_we    = req_we[k];
                w_sel_addr  = req_addr[k*D +: D];
                w_sel_wdata = req_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge system_clk or negedge prstn) begin
        if (!prstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM: next state. cfg_mode is only looked at in IDLE and CFG, so a
    // window request arriving mid-transaction waits for the return to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cfg_mode) begin
                    w_next = ST_CFG;
                end else if (|req) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: w_next = r_we ? ST_IDLE : ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            ST_CFG:   w_next = cfg_mode ? ST_CFG : ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    assign w_take = (r_state == ST_IDLE) && (w_next == ST_ISSUE);

    // Latched transaction, round-robin pointer, read return and cfg enable.
    always_ff @(posedge system_clk or negedge prstn) begin
        if (!prstn) begin
            r_rr_ptr <= '0;
            r_idx    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_rvalid <= '0;
            r_cfg_we <= 1'b0;
        end else begin
            if (w_take) begin
                r_idx   <= w_win_idx;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
            if (r_state == ST_ISSUE) begin
                r_rr_ptr <= (r_idx == IW'(N - 1)) ? '0 : r_idx + 1'b1;
            end
            if (r_state == ST_RESP) begin
                r_rdata <= mem_rd_data;
            end
            r_rvalid <= (r_state == ST_RESP) ? w_lat_onehot : '0;
            // Registered copy of "in CFG": rises on entry, falls on exit.
            r_cfg_we <= (w_next == ST_CFG);
        end
    end

    assign w_lat_onehot = N'(1) << r_idx;

    assign gnt                    = (r_state == ST_ISSUE) ? w_lat_onehot : '0;
    assign mem_rd_en              = (r_state == ST_ISSUE) && !r_we;
    assign mem_wr_en              = (r_state == ST_ISSUE) &&  r_we;
    assign mem_addr               = r_addr;
    assign mem_wdata              = r_wdata;
    assign rdata                  = r_rdata;
    assign rvalid                 = r_rvalid;
    assign cfg_state_write_enable = r_cfg_we;

endmodule
